// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : MIPS IF stage. Owns the PC and the IF/ID register. Handles stall,
//            ID redirect, flush, halt and stop on out-of-range fetch.
//            Optional macro MISALIGN_TRAP_EN adds a misaligned-redirect trap
//            and a misalignOut port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stallIn,
    input  logic        flushIn,
    input  logic        redirectIn,
    input  logic [31:0] redirectTargetIn,
    input  logic        haltIn,
    input  logic [31:0] instructionIn,
    output logic [31:0] programCounterOut,
    output logic [31:0] ifIdInstructionOut,
    output logic [31:0] ifIdPCPlus4Out,
    output logic        ifIdValidOut,
    output logic        haltedOut,
    output logic [31:0] fetchCountOut
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalignOut
`endif
);

    localparam logic [31:0] c_PC_LIMIT  = 32'(MEM_DEPTH * 4);
    localparam logic [31:0] c_COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] target_w;
    logic        target_bad_w;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    assign pc_plus4_w = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
    assign target_w     = redirectTargetIn;
    assign target_bad_w = (redirectTargetIn[1:0] != 2'b00);
`else
    // Without the trap, the low bits are simply dropped to keep the PC word aligned.
    assign target_w     = redirectTargetIn & ~32'h0000_0003;
    assign target_bad_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_START: begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (haltIn) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    state_d = S_HALTED;
                end else if (redirectIn) begin
                    // Redirect wins over stall: the fetched word on the wrong path is dropped.
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    if (target_bad_w) begin
                        state_d = S_HALTED;
`ifdef MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        pc_d = target_w;
                    end
                end else if (pc_q >= c_PC_LIMIT) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    state_d = S_HALTED;
                end else if (flushIn) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    if (!stallIn) begin
                        pc_d = pc_plus4_w;
                    end
                end else if (!stallIn) begin
                    instr_d = instructionIn;
                    pc4_d   = pc_plus4_w;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4_w;
                    if (count_q != c_COUNT_MAX) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            S_HALTED: begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
            default: begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign programCounterOut  = pc_q;
    assign ifIdInstructionOut = instr_q;
    assign ifIdPCPlus4Out     = pc4_q;
    assign ifIdValidOut       = valid_q;
    assign haltedOut          = (state_q == S_HALTED);
    assign fetchCountOut      = count_q;
`ifdef MISALIGN_TRAP_EN
    assign misalignOut        = misalign_q;
`endif

endmodule

`default_nettype wire
